// File: rtl/xcvr_reconfig_mgmt_master_if.sv
// Command/response and Avalon-MM management signals for the reconfig master.
// The master modport is the view of xcvr_reconfig_mgmt_master; slave is its environment.
interface xcvr_reconfig_mgmt_master_if #(
  parameter int CH_W = 10
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic            cmd_rmw;
  logic [CH_W-1:0] cmd_channel;
  logic [5:0]      cmd_offset;
  logic [15:0]     cmd_wdata;
  logic [15:0]     cmd_mask;
  logic            rsp_valid;
  logic [15:0]     rsp_rdata;
  logic            rsp_error;
  logic [6:0]      reconfig_mgmt_address;
  logic            reconfig_mgmt_read;
  logic            reconfig_mgmt_write;
  logic [31:0]     reconfig_mgmt_writedata;
  logic            reconfig_mgmt_waitrequest;
  logic [31:0]     reconfig_mgmt_readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_rmw, cmd_channel, cmd_offset, cmd_wdata, cmd_mask,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output reconfig_mgmt_address, reconfig_mgmt_read, reconfig_mgmt_write,
    output reconfig_mgmt_writedata,
    input  reconfig_mgmt_waitrequest, reconfig_mgmt_readdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_rmw, cmd_channel, cmd_offset, cmd_wdata, cmd_mask,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  reconfig_mgmt_address, reconfig_mgmt_read, reconfig_mgmt_write,
    input  reconfig_mgmt_writedata,
    output reconfig_mgmt_waitrequest, reconfig_mgmt_readdata
  );
endinterface

// File: rtl/xcvr_reconfig_mgmt_master.sv
// Converts single channel-register commands into the reconfig controller's indirect
// access sequence over Avalon-MM. Define XCVR_RECONFIG_MASTER_RMW_EN for read-modify-write.
module xcvr_reconfig_mgmt_master #(
  parameter logic [6:0] BASE_ADDR    = 7'h08,
  parameter int         CH_W         = 10,
  parameter int         POLL_TIMEOUT = 1023
) (
  input logic                         mgmt_clk_clk,
  input logic                         mgmt_rst_reset,
  xcvr_reconfig_mgmt_master_if.master bus
);
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CH, S_WR_OFS, S_WR_DATA, S_WR_CTRL, S_POLL, S_RD_DATA, S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [5:0]      ofs_q, ofs_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            op_wr_q, op_wr_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [PCW-1:0]  poll_q, poll_d;
  logic [6:0]      addr_q, addr_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [31:0]     wdat32_q, wdat32_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            done_s;
  logic            unused_s;
`ifdef XCVR_RECONFIG_MASTER_RMW_EN
  logic [15:0]     mask_q, mask_d;
  logic            rmw_q, rmw_d;

  assign unused_s = ^bus.reconfig_mgmt_readdata[31:16];
`else
  assign unused_s = ^{bus.reconfig_mgmt_readdata[31:16], bus.cmd_rmw, bus.cmd_mask};
`endif

  assign done_s = (rd_q || wr_q) && !bus.reconfig_mgmt_waitrequest;

  // Sequencer next state, latched command fields and registered bus/response outputs
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    ofs_d       = ofs_q;
    wdata_d     = wdata_q;
    op_wr_d     = op_wr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    poll_d      = poll_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    wdat32_d    = wdat32_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 16'h0;
    rsp_error_d = 1'b0;
    cmd_ready_d = 1'b0;
`ifdef XCVR_RECONFIG_MASTER_RMW_EN
    mask_d      = mask_q;
    rmw_d       = rmw_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d = S_WR_CH;
          ch_d    = bus.cmd_channel;
          ofs_d   = bus.cmd_offset;
          wdata_d = bus.cmd_wdata;
          rdata_d = 16'h0;
          err_d   = 1'b0;
          poll_d  = '0;
`ifdef XCVR_RECONFIG_MASTER_RMW_EN
          mask_d  = bus.cmd_mask;
          rmw_d   = bus.cmd_rmw;
          op_wr_d = bus.cmd_write && !bus.cmd_rmw;
`else
          op_wr_d = bus.cmd_write;
`endif
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_WR_CH:   state_d = done_s ? S_WR_OFS : S_WR_CH;
      S_WR_OFS:  state_d = done_s ? (op_wr_q ? S_WR_DATA : S_WR_CTRL) : S_WR_OFS;
      S_WR_DATA: state_d = done_s ? S_WR_CTRL : S_WR_DATA;
      S_WR_CTRL: state_d = done_s ? S_POLL : S_WR_CTRL;
      S_POLL: begin
        if (!done_s) begin
          state_d = S_POLL;
        end else if (bus.reconfig_mgmt_readdata[8]) begin
          // Busy: give up once the budget is spent, otherwise count and poll again
          if (poll_q == POLL_MAX) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            poll_d  = poll_q + PCW'(1);
          end
        end else begin
          err_d   = bus.reconfig_mgmt_readdata[9];
          state_d = (bus.reconfig_mgmt_readdata[9] || op_wr_q) ? S_RESP : S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (done_s) begin
          rdata_d = bus.reconfig_mgmt_readdata[15:0];
          state_d = S_RESP;
`ifdef XCVR_RECONFIG_MASTER_RMW_EN
          if (rmw_q) begin
            rmw_d   = 1'b0;
            op_wr_d = 1'b1;
            poll_d  = '0;
            wdata_d = (bus.reconfig_mgmt_readdata[15:0] & ~mask_q) | (wdata_q & mask_q);
            state_d = S_WR_DATA;
          end else begin
            rmw_d   = 1'b0;
          end
`endif
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_error_d = err_q;
        rsp_rdata_d = err_q ? 16'h0 : rdata_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Load the next transfer right as the previous one completes (or on sequence start)
    if ((state_q != S_IDLE) && (done_s || !(rd_q || wr_q))) begin
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      wdat32_d = 32'h0;
      case (state_d)
        S_WR_CH:   begin addr_d = BASE_ADDR;         wr_d = 1'b1; wdat32_d = 32'(ch_d); end
        S_WR_OFS:  begin addr_d = BASE_ADDR + 7'd3;  wr_d = 1'b1; wdat32_d = 32'(ofs_d); end
        S_WR_DATA: begin addr_d = BASE_ADDR + 7'd4;  wr_d = 1'b1; wdat32_d = {16'h0, wdata_d}; end
        S_WR_CTRL: begin
          addr_d   = BASE_ADDR + 7'd2;
          wr_d     = 1'b1;
          wdat32_d = op_wr_d ? 32'h0000_0001 : 32'h0000_0002;
        end
        S_POLL:    begin addr_d = BASE_ADDR + 7'd2;  rd_d = 1'b1; end
        S_RD_DATA: begin addr_d = BASE_ADDR + 7'd4;  rd_d = 1'b1; end
        default:   addr_d = addr_q;
      endcase
    end else begin
      wdat32_d = wdat32_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge mgmt_clk_clk) begin
    if (mgmt_rst_reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      ofs_q       <= 6'h0;
      wdata_q     <= 16'h0;
      op_wr_q     <= 1'b0;
      rdata_q     <= 16'h0;
      err_q       <= 1'b0;
      poll_q      <= '0;
      addr_q      <= 7'h0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdat32_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0;
      rsp_error_q <= 1'b0;
      cmd_ready_q <= 1'b1;
`ifdef XCVR_RECONFIG_MASTER_RMW_EN
      mask_q      <= 16'h0;
      rmw_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      ofs_q       <= ofs_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      poll_q      <= poll_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      wdat32_q    <= wdat32_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef XCVR_RECONFIG_MASTER_RMW_EN
      mask_q      <= mask_d;
      rmw_q       <= rmw_d;
`endif
    end
  end

  assign bus.cmd_ready               = cmd_ready_q;
  assign bus.rsp_valid               = rsp_valid_q;
  assign bus.rsp_rdata               = rsp_rdata_q;
  assign bus.rsp_error               = rsp_error_q;
  assign bus.reconfig_mgmt_address   = addr_q;
  assign bus.reconfig_mgmt_read      = rd_q;
  assign bus.reconfig_mgmt_write     = wr_q;
  assign bus.reconfig_mgmt_writedata = wdat32_q;
endmodule
